softmax_sum_reciprocal: RTL and testbench

Upstream stage of the 32-element softmax datapath. Collects one frame of `NUM_ELEM` exponent values (Q4.12), buffers them, and accumulates their sum. It then computes the Q0.16 reciprocal of the sum with a fixed-latency sequential divider. Finally it streams each buffered exponent, paired with the frame's reciprocal, into the normalising multiplier (exp × 1/sum).

---
 rtl/softmax_sum_reciprocal.sv | 140 ++++++++++++++
 tb/tb_softmax_sum_reciprocal.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/softmax_sum_reciprocal.sv
// Softmax sum stage: buffers one frame of exponents, sums them,
// divides 2^28 by the sum, then streams exp with the frame reciprocal.
module softmax_sum_reciprocal #(
   parameter int BIT_WIDTH = 16,
   parameter int NUM_ELEM  = 32,
   parameter int ACC_WIDTH = BIT_WIDTH - 1 + $clog2(NUM_ELEM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic [BIT_WIDTH-1:0] i_data,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [BIT_WIDTH-1:0] o_expData,
   output logic [BIT_WIDTH-1:0] o_recip,
   output logic                 o_last,
   input  logic                 i_ready
);

   localparam int CW   = $clog2(NUM_ELEM);
   localparam int IW   = $clog2(BIT_WIDTH);
   localparam int RW   = ACC_WIDTH + 1;
   localparam int FRAC = BIT_WIDTH - 4;

   localparam logic [CW-1:0]        LAST    = CW'(NUM_ELEM - 1);
   localparam logic [IW-1:0]        IT_LAST = IW'(BIT_WIDTH - 1);
   localparam logic [RW-1:0]        R_INIT  = RW'(1) << FRAC;
   localparam logic [ACC_WIDTH-1:0] ONE     = ACC_WIDTH'(1) << FRAC;

   typedef enum logic [1:0] {
      ACCUM,
      DIVIDE,
      EMIT
   } state_t;

   state_t state, state_nxt;

   logic [BIT_WIDTH-1:0] buf_mem [NUM_ELEM];
   logic [ACC_WIDTH-1:0] sum;
   logic [CW-1:0]        wr_cnt;
   logic [CW-1:0]        rd_cnt;
   logic [IW-1:0]        it;
   logic [RW-1:0]        rem;
   logic [RW-1:0]        rem_sh;
   logic [RW-1:0]        rem_nxt;
   logic [BIT_WIDTH-1:0] quot;
   logic [BIT_WIDTH-1:0] quot_nxt;
   logic [BIT_WIDTH-1:0] recip;
   logic [BIT_WIDTH-1:0] clamped;
   logic                 ready_q;
   logic                 accept;
   logic                 q_bit;

   assign accept  = (state == ACCUM) && i_valid && ready_q;
   assign clamped = i_data[BIT_WIDTH-1] ? '0 : i_data;

   // one restoring-division step
   assign rem_sh   = rem << 1;
   assign q_bit    = (rem_sh >= RW'(sum));
   assign rem_nxt  = q_bit ? (rem_sh - RW'(sum)) : rem_sh;
   assign quot_nxt = {quot[BIT_WIDTH-2:0], q_bit};

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCUM:  if (accept && wr_cnt == LAST) state_nxt = DIVIDE;
         DIVIDE: if (it == IT_LAST) state_nxt = EMIT;
         EMIT:   if (i_ready && rd_cnt == LAST) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (accept) buf_mem[wr_cnt] <= clamped;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         sum     <= '0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         it      <= '0;
         rem     <= '0;
         quot    <= '0;
         recip   <= '0;
      end else begin
         ready_q <= (state_nxt == ACCUM);
         unique case (state)
            ACCUM: begin
               if (accept) begin
                  sum <= sum + ACC_WIDTH'(clamped);
                  if (wr_cnt == LAST) begin
                     wr_cnt <= '0;
                     rem    <= R_INIT;
                     it     <= '0;
                     quot   <= '0;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            DIVIDE: begin
               rem  <= rem_nxt;
               quot <= quot_nxt;
               it   <= it + 1'b1;
               // special sums override the quotient on the final step
               if (it == IT_LAST) begin
                  if (sum == '0)       recip <= '0;
                  else if (sum <= ONE) recip <= '1;
                  else                 recip <= quot_nxt;
               end
            end
            EMIT: begin
               if (i_ready) begin
                  if (rd_cnt == LAST) begin
                     rd_cnt <= '0;
                     sum    <= '0;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready   = ready_q;
   assign o_valid   = (state == EMIT);
   assign o_expData = (state == EMIT) ? buf_mem[rd_cnt] : '0;
   assign o_recip   = recip;
   assign o_last    = (state == EMIT) && (rd_cnt == LAST);

endmodule

// File: tb/tb_softmax_sum_reciprocal.sv
// Bench for softmax_sum_reciprocal: frames driven from a table,
// expected outputs queued per element and checked as they emerge.
module tb_softmax_sum_reciprocal;

   localparam int BW = 16;
   localparam int NE = 32;

   typedef struct packed {
      logic          last;
      logic [BW-1:0] recip;
      logic [BW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic [BW-1:0] i_data = '0;
   logic          i_ready = 1'b1;
   logic          o_ready;
   logic          o_valid;
   logic [BW-1:0] o_expData;
   logic [BW-1:0] o_recip;
   logic          o_last;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   n_pop = 0;
   logic prev_valid = 1'b0;
   exp_t sb [$];
   exp_t e;

   softmax_sum_reciprocal dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .o_ready   (o_ready),
      .o_valid   (o_valid),
      .o_expData (o_expData),
      .o_recip   (o_recip),
      .o_last    (o_last),
      .i_ready   (i_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // output monitor: compare against scoreboard head, pop on transfer
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (o_valid && !prev_valid)
            check("latency", cyc - last_acc, 16);
         if (o_valid) begin
            if (sb.size() == 0) begin
               check("sb_empty", 1, 0);
            end else begin
               e = sb[0];
               check("data", {16'h0, o_expData}, {16'h0, e.data});
               check("recip", {16'h0, o_recip}, {16'h0, e.recip});
               check("last", {31'h0, o_last}, {31'h0, e.last});
               if (i_ready) begin
                  void'(sb.pop_front());
                  n_pop++;
               end
            end
         end else begin
            check("idle", {15'h0, o_last, o_expData}, 0);
         end
      end
      prev_valid = o_valid && !rst;
   end

   task automatic send_frame(input logic [BW-1:0] v [NE]);
      longint        s;
      logic [BW-1:0] r;
      logic [BW-1:0] c;
      int            n;
      s = 0;
      for (int i = 0; i < NE; i++) s += v[i][BW-1] ? 0 : longint'(v[i]);
      if (s == 0)         r = 16'h0000;
      else if (s <= 4096) r = 16'hFFFF;
      else                r = 16'(longint'(268435456) / s);
      for (int i = 0; i < NE; i++) begin
         c = v[i][BW-1] ? 16'h0 : v[i];
         sb.push_back('{last: (i == NE - 1), recip: r, data: c});
      end
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
         i_valid = 1'b1;
         i_data  = v[i];
         n = 0;
         while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (!o_ready) check("ready_timeout", 0, 1);
         if (i == NE - 1) last_acc = cyc + 1;
         @(negedge clk);
      end
      // junk kept on the input while the block must refuse it
      i_data = 16'h7FFF;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
      i_valid = 1'b0;
   endtask

   task automatic wait_pops(input int base, input int cnt);
      int n;
      n = 0;
      while (n_pop - base < cnt && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("pop_wait", n_pop - base, cnt);
   endtask

   logic [BW-1:0] fr [NE];
   int base;

   initial begin
      #1;
      check("rst_out", {o_ready, o_valid, o_last, o_expData, o_recip},
            0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("ready_pre", {31'h0, o_ready}, 0);
      @(posedge clk);
      #1 check("ready_up", {31'h0, o_ready}, 1);

      foreach (fr[i]) fr[i] = 16'h1000;
      send_frame(fr);
      wait_drain();

      foreach (fr[i]) fr[i] = 16'h7FFF;
      send_frame(fr);
      wait_drain();

      foreach (fr[i]) fr[i] = 16'h2000;
      fr[7] = 16'hF000;
      send_frame(fr);
      wait_drain();

      foreach (fr[i]) fr[i] = 16'h0000;
      fr[5] = 16'h1000;
      send_frame(fr);
      wait_drain();

      foreach (fr[i]) fr[i] = 16'h0000;
      send_frame(fr);
      wait_drain();

      for (int k = 0; k < 3; k++) begin
         foreach (fr[i]) fr[i] = 16'($urandom_range(0, 65535));
         send_frame(fr);
         wait_drain();
      end

      // downstream stall of three cycles at element 12
      foreach (fr[i]) fr[i] = 16'(16'h0100 + i * 16'h0040);
      base = n_pop;
      send_frame(fr);
      wait_pops(base, 12);
      @(posedge clk);
      #1 i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 i_ready = 1'b1;
      wait_drain();
      check("bp_count", n_pop - base, NE);

      // reset while emitting element 10
      foreach (fr[i]) fr[i] = 16'h1000;
      base = n_pop;
      send_frame(fr);
      wait_pops(base, 10);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("mid_rst", {o_ready, o_valid, o_last, o_expData, o_recip},
               0);
      sb.delete();
      i_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("rel_ready", {31'h0, o_ready}, 0);
      @(posedge clk);
      #1 check("rel_up", {31'h0, o_ready}, 1);

      foreach (fr[i]) fr[i] = 16'h1000;
      send_frame(fr);
      wait_drain();

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
